// File: rtl/audio_cue_pkg.sv
// -----------------------------------------------------------------------------
// audio_cue_pkg
//
// Shared constants and helpers for the audio cue sequencer:
//   - widths of the note index, the alien counter and the fleet period;
//   - the four-note fleet march tone table (Hz);
//   - a millisecond-to-clock-cycle helper, evaluated at elaboration time only.
//
// No ports (package).
// -----------------------------------------------------------------------------
package audio_cue_pkg;

    // Four march notes -> two-bit index that wraps naturally.
    localparam int unsigned NOTE_IDX_W     = 2;

    // Up to 55 live aliens.
    localparam int unsigned ALIEN_CNT_W    = 6;

    // Square-wave period handed to the audio unit, in clock cycles.
    localparam int unsigned FLEET_PERIOD_W = 32;

    // Fleet march tones, descending, in Hz.
    localparam int unsigned TONE_HZ_0 = 62;
    localparam int unsigned TONE_HZ_1 = 55;
    localparam int unsigned TONE_HZ_2 = 49;
    localparam int unsigned TONE_HZ_3 = 44;

    typedef logic [NOTE_IDX_W-1:0]     note_idx_t;
    typedef logic [ALIEN_CNT_W-1:0]    alien_cnt_t;
    typedef logic [FLEET_PERIOD_W-1:0] fleet_period_t;

    // Tone lookup by note index. Only ever called with constant arguments,
    // so it folds into localparams and never becomes a hardware divider.
    function automatic int unsigned tone_hz(input int unsigned idx);
        int unsigned hz;
        case (idx)
            0:       hz = TONE_HZ_0;
            1:       hz = TONE_HZ_1;
            2:       hz = TONE_HZ_2;
            default: hz = TONE_HZ_3;
        endcase
        return hz;
    endfunction

    // Milliseconds to clock cycles; divide first so large clocks do not
    // overflow 32-bit arithmetic.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                                 input int unsigned ms);
        return (clk_freq / 1000) * ms;
    endfunction

endpackage

// File: rtl/cue_edge_detect.sv
// -----------------------------------------------------------------------------
// cue_edge_detect
//
// Rise/fall pulse generator for a level input. The previous level is held in a
// register; rise/fall are decoded from that register and the live input, so
// they are valid in the same cycle the input changes and the consumer can
// register them without adding a second cycle of latency.
//
// The history register only updates while 'en' is high, and no edge is
// reported while 'en' is low. A change that happens while disabled therefore
// shows up as an edge on the first enabled cycle.
//
// Ports:
//   clk   in  1  system clock
//   rst   in  1  synchronous reset, active-high (history cleared to 0)
//   en    in  1  update / report enable
//   sig   in  1  level being watched
//   rise  out 1  sig is 1 and the remembered level is 0 (while en)
//   fall  out 1  sig is 0 and the remembered level is 1 (while en)
// -----------------------------------------------------------------------------
module cue_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else if (en) begin
            prev <= sig;
        end
    end

    assign rise = en &  sig & ~prev;
    assign fall = en & ~sig &  prev;

endmodule

// File: rtl/audio_cue_sequencer.sv
// -----------------------------------------------------------------------------
// audio_cue_sequencer
//
// Turns raw game-logic events into control inputs for the audio unit:
//   - fleet_period: square-wave period of the current march note (0 = silent);
//   - one-cycle play/stop pulses for the PCM channels.
// Owns the four-note march sequence, UFO start/stop edge detection, event
// priority, and a freeze window after a player hit during which lower
// priority cues are dropped.
//
// Event interface: every ev_* and fleet_step input is a single-cycle pulse
// that is sampled on exactly one clock edge; there is no back-pressure, and
// anything that cannot be acted on in that cycle is discarded, never queued.
// Every output is registered; each output pulse lasts exactly one cycle and
// appears on the edge that samples its cause.
//
// Compile-time option:
//   AUDIO_FLEET_SPEEDUP_EN  when defined, the note length shrinks as the
//                           fleet thins out (half at <= 8 aliens, quarter at
//                           exactly 1). Undefined: every note is NOTE_CYCLES.
//
// Parameters:
//   CLK_FREQ   system clock in Hz
//   NOTE_MS    march note duration in ms
//   FREEZE_MS  cue suppression window after a player hit, in ms
//
// Ports:
//   clk              in  1   system clock
//   rst              in  1   synchronous reset, active-high
//   game_running     in  1   level; cues allowed only while high
//   fleet_step       in  1   pulse; fleet advanced one step
//   alien_count      in  6   live aliens, 0..55
//   ufo_active       in  1   level; UFO on screen
//   ev_shoot         in  1   pulse; player fired
//   ev_player_hit    in  1   pulse; player destroyed
//   ev_alien_hit     in  1   pulse; alien destroyed
//   ev_ufo_hit       in  1   pulse; UFO destroyed
//   fleet_period     out 32  march square period in clk cycles, 0 = silent
//   play_ufo         out 1   pulse; start UFO loop
//   stop_ufo         out 1   pulse; stop UFO loop
//   play_shoot       out 1   pulse
//   play_player_hit  out 1   pulse
//   play_alien_hit   out 1   pulse
//   play_ufo_hit     out 1   pulse
// -----------------------------------------------------------------------------
module audio_cue_sequencer
    import audio_cue_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned NOTE_MS   = 100,
    parameter int unsigned FREEZE_MS = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      game_running,
    input  logic                      fleet_step,
    input  logic [ALIEN_CNT_W-1:0]    alien_count,
    input  logic                      ufo_active,
    input  logic                      ev_shoot,
    input  logic                      ev_player_hit,
    input  logic                      ev_alien_hit,
    input  logic                      ev_ufo_hit,
    output logic [FLEET_PERIOD_W-1:0] fleet_period,
    output logic                      play_ufo,
    output logic                      stop_ufo,
    output logic                      play_shoot,
    output logic                      play_player_hit,
    output logic                      play_alien_hit,
    output logic                      play_ufo_hit
);

    // -------------------------------------------------------------------------
    // Elaboration-time constants
    // -------------------------------------------------------------------------
    localparam int unsigned TIMER_W = 32;

    localparam logic [TIMER_W-1:0] NOTE_CYCLES   = TIMER_W'(ms_to_cycles(CLK_FREQ, NOTE_MS));
    localparam logic [TIMER_W-1:0] FREEZE_CYCLES = TIMER_W'(ms_to_cycles(CLK_FREQ, FREEZE_MS));

    // Integer-truncated periods of the four march tones.
    localparam fleet_period_t PERIOD_0 = FLEET_PERIOD_W'(CLK_FREQ / tone_hz(0));
    localparam fleet_period_t PERIOD_1 = FLEET_PERIOD_W'(CLK_FREQ / tone_hz(1));
    localparam fleet_period_t PERIOD_2 = FLEET_PERIOD_W'(CLK_FREQ / tone_hz(2));
    localparam fleet_period_t PERIOD_3 = FLEET_PERIOD_W'(CLK_FREQ / tone_hz(3));

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    note_idx_t            note_idx;      // next note to play
    logic [TIMER_W-1:0]   note_timer;    // cycles left in current note
    logic [TIMER_W-1:0]   freeze_timer;  // cycles left in post-hit freeze

    // -------------------------------------------------------------------------
    // Edge detection
    // -------------------------------------------------------------------------
    logic ufo_rise;
    logic ufo_fall;
    logic gr_rise;
    logic gr_fall;

    // The UFO history only tracks while the game runs, so a UFO already on
    // screen when play starts (e.g. right after reset) still gets play_ufo.
    cue_edge_detect u_ufo_edge (
        .clk  (clk),
        .rst  (rst),
        .en   (game_running),
        .sig  (ufo_active),
        .rise (ufo_rise),
        .fall (ufo_fall)
    );

    cue_edge_detect u_gr_edge (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .sig  (game_running),
        .rise (gr_rise),
        .fall (gr_fall)
    );

    // -------------------------------------------------------------------------
    // Event qualification
    // -------------------------------------------------------------------------
    logic frozen;
    logic accept;     // cues may be acted on this cycle at all
    logic hit_ok;     // player hit takes effect
    logic cue_ok;     // ordinary cues take effect (no player hit this cycle)
    logic step_ok;    // a march note starts this cycle
    logic stop_any;   // any stop_ufo source, collapsed to one pulse

    assign frozen   = (freeze_timer != '0);
    assign accept   = game_running & ~frozen;
    assign hit_ok   = accept & ev_player_hit;
    assign cue_ok   = accept & ~ev_player_hit;
    assign step_ok  = cue_ok & fleet_step & (alien_count != '0);

    // A falling UFO edge stops the loop even while frozen; game_running
    // dropping silences the UFO unconditionally.
    assign stop_any = gr_fall | hit_ok | ufo_fall | (cue_ok & ev_ufo_hit);

    // -------------------------------------------------------------------------
    // Note selection
    // -------------------------------------------------------------------------
    note_idx_t          idx_eff;
    fleet_period_t      next_period;
    logic [TIMER_W-1:0] note_len;

    // A game start restarts the march at the first note, including a step
    // that lands in the very same cycle.
    assign idx_eff = gr_rise ? '0 : note_idx;

    always_comb begin
        next_period = PERIOD_0;
        case (idx_eff)
            2'd0:    next_period = PERIOD_0;
            2'd1:    next_period = PERIOD_1;
            2'd2:    next_period = PERIOD_2;
            default: next_period = PERIOD_3;
        endcase
    end

    always_comb begin
        note_len = NOTE_CYCLES;
`ifdef AUDIO_FLEET_SPEEDUP_EN
        // The single-survivor check must come first: 1 is also <= 8.
        if (alien_count == ALIEN_CNT_W'(1)) begin
            note_len = NOTE_CYCLES >> 2;
        end else if (alien_count <= ALIEN_CNT_W'(8)) begin
            note_len = NOTE_CYCLES >> 1;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Registered outputs and timers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fleet_period    <= '0;
            play_ufo        <= 1'b0;
            stop_ufo        <= 1'b0;
            play_shoot      <= 1'b0;
            play_player_hit <= 1'b0;
            play_alien_hit  <= 1'b0;
            play_ufo_hit    <= 1'b0;
            note_idx        <= '0;
            note_timer      <= '0;
            freeze_timer    <= '0;
        end else begin
            play_shoot      <= cue_ok & ev_shoot;
            play_alien_hit  <= cue_ok & ev_alien_hit;
            play_ufo_hit    <= cue_ok & ev_ufo_hit;
            play_player_hit <= hit_ok;
            stop_ufo        <= stop_any;
            // Stop beats start when both land in one cycle.
            play_ufo        <= cue_ok & ufo_rise & ~stop_any;

            if (!game_running) begin
                // Idle game: silent march, no pending freeze or note.
                fleet_period <= '0;
                note_timer   <= '0;
                freeze_timer <= '0;
            end else if (hit_ok) begin
                fleet_period <= '0;
                note_timer   <= '0;
                freeze_timer <= FREEZE_CYCLES;
                if (gr_rise) begin
                    note_idx <= '0;
                end
            end else begin
                if (frozen) begin
                    freeze_timer <= freeze_timer - TIMER_W'(1);
                end

                if (step_ok) begin
                    // A step mid-note replaces the current note outright,
                    // so the march never has a silent gap between steps.
                    fleet_period <= next_period;
                    note_timer   <= note_len;
                    note_idx     <= idx_eff + NOTE_IDX_W'(1);
                end else begin
                    if (gr_rise) begin
                        note_idx <= '0;
                    end
                    if (note_timer != '0) begin
                        note_timer <= note_timer - TIMER_W'(1);
                        if (note_timer == TIMER_W'(1)) begin
                            fleet_period <= '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_cue_sequencer.sv
// -----------------------------------------------------------------------------
// tb_audio_cue_sequencer
//
// Directed steps followed by a randomized phase. Every cycle the full output
// vector is compared against a reference model that works in absolute cycle
// numbers (when a note ends, when the freeze ends, how many notes have been
// played) rather than countdown timers. Key points of each scenario are also
// checked against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_audio_cue_sequencer;

    localparam int unsigned TB_CLK_FREQ  = 100_000;
    localparam int unsigned TB_NOTE_MS   = 100;
    localparam int unsigned TB_FREEZE_MS = 50;
    localparam longint NOTE_CYC   = 10000;
    localparam longint FREEZE_CYC = 5000;
    localparam int OUT_W = 38;

`ifdef AUDIO_FLEET_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    // ---------------------------------------------------------------- signals
    logic        clk = 1'b0;
    logic        rst;
    logic        game_running;
    logic        fleet_step;
    logic [5:0]  alien_count;
    logic        ufo_active;
    logic        ev_shoot;
    logic        ev_player_hit;
    logic        ev_alien_hit;
    logic        ev_ufo_hit;
    logic [31:0] fleet_period;
    logic        play_ufo;
    logic        stop_ufo;
    logic        play_shoot;
    logic        play_player_hit;
    logic        play_alien_hit;
    logic        play_ufo_hit;

    int checks = 0;
    int errors = 0;

    logic [OUT_W-1:0] exp_q[$];

    audio_cue_sequencer #(
        .CLK_FREQ  (TB_CLK_FREQ),
        .NOTE_MS   (TB_NOTE_MS),
        .FREEZE_MS (TB_FREEZE_MS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .game_running    (game_running),
        .fleet_step      (fleet_step),
        .alien_count     (alien_count),
        .ufo_active      (ufo_active),
        .ev_shoot        (ev_shoot),
        .ev_player_hit   (ev_player_hit),
        .ev_alien_hit    (ev_alien_hit),
        .ev_ufo_hit      (ev_ufo_hit),
        .fleet_period    (fleet_period),
        .play_ufo        (play_ufo),
        .stop_ufo        (stop_ufo),
        .play_shoot      (play_shoot),
        .play_player_hit (play_player_hit),
        .play_alien_hit  (play_alien_hit),
        .play_ufo_hit    (play_ufo_hit)
    );

    // ------------------------------------------------------- clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------- reference model
    longint    m_cyc = 0;
    longint    m_note_end;
    longint    m_freeze_end;
    int        m_note_count;
    logic [31:0] m_period;
    logic      m_gr_prev;
    logic      m_ufo_seen;

    function automatic logic [31:0] tone_period(input int idx);
        int hz;
        case (idx)
            0:       hz = 62;
            1:       hz = 55;
            2:       hz = 49;
            default: hz = 44;
        endcase
        return 32'(TB_CLK_FREQ / hz);
    endfunction

    function automatic longint note_len(input int count);
        if (SPEEDUP && count == 1) return NOTE_CYC / 4;
        if (SPEEDUP && count <= 8) return NOTE_CYC / 2;
        return NOTE_CYC;
    endfunction

    // Computes what the outputs must be after the coming clock edge, given
    // the inputs currently applied, and queues it.
    task automatic model_eval();
        logic [31:0] per;
        logic p_ufo, s_ufo, p_sh, p_ph, p_ah, p_uh;
        logic gr_rise, gr_fall, u_rise, u_fall;
        p_ufo = 0; s_ufo = 0; p_sh = 0; p_ph = 0; p_ah = 0; p_uh = 0;
        per = 0;
        if (rst) begin
            m_note_end   = 0;
            m_freeze_end = 0;
            m_note_count = 0;
            m_period     = 0;
            m_gr_prev    = 0;
            m_ufo_seen   = 0;
        end else begin
            gr_rise   = game_running && !m_gr_prev;
            gr_fall   = !game_running && m_gr_prev;
            m_gr_prev = game_running;
            u_rise = 0;
            u_fall = 0;
            if (game_running) begin
                u_rise     = ufo_active && !m_ufo_seen;
                u_fall     = !ufo_active && m_ufo_seen;
                m_ufo_seen = ufo_active;
            end
            if (gr_rise) m_note_count = 0;
            if (!game_running) begin
                m_note_end   = 0;
                m_freeze_end = 0;
                s_ufo        = gr_fall;
            end else if (m_cyc < m_freeze_end) begin
                s_ufo = u_fall;
            end else if (ev_player_hit) begin
                p_ph         = 1;
                s_ufo        = 1;
                m_note_end   = 0;
                m_freeze_end = m_cyc + FREEZE_CYC + 1;
            end else begin
                p_sh  = ev_shoot;
                p_ah  = ev_alien_hit;
                p_uh  = ev_ufo_hit;
                s_ufo = u_fall || ev_ufo_hit;
                p_ufo = u_rise && !s_ufo;
                if (fleet_step && alien_count != 0) begin
                    m_period     = tone_period(m_note_count % 4);
                    m_note_end   = m_cyc + note_len(int'(alien_count));
                    m_note_count = m_note_count + 1;
                end
            end
            per = (m_cyc < m_note_end) ? m_period : 32'd0;
        end
        m_cyc = m_cyc + 1;
        exp_q.push_back({per, p_ufo, s_ufo, p_sh, p_ph, p_ah, p_uh});
    endtask

    // ------------------------------------------------------------- scoreboard
    task automatic check_out();
        logic [OUT_W-1:0] exp_v;
        logic [OUT_W-1:0] obs_v;
        exp_v = exp_q.pop_front();
        obs_v = {fleet_period, play_ufo, stop_ufo, play_shoot,
                 play_player_hit, play_alien_hit, play_ufo_hit};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL model_outputs cyc=%0d observed=%h expected=%h", m_cyc, obs_v, exp_v);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic cycle();
        model_eval();
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_pulses();
        fleet_step    = 0;
        ev_shoot      = 0;
        ev_player_hit = 0;
        ev_alien_hit  = 0;
        ev_ufo_hit    = 0;
    endtask

    task automatic pulse_step();
        fleet_step = 1;
        cycle();
        fleet_step = 0;
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        rst = 1; game_running = 0; alien_count = 6'd55; ufo_active = 0;
        clear_pulses();
        idle(3);
        check_val("reset_period", fleet_period, 32'd0);
        check_val("reset_pulses", 32'({play_ufo, stop_ufo, play_shoot, play_player_hit,
                                       play_alien_hit, play_ufo_hit}), 32'd0);
        rst = 0; game_running = 1;
        idle(3);

        // March sequence and note length.
        pulse_step();
        check_val("t1_note0_start", fleet_period, 32'd1612);
        idle(9999);
        check_val("t1_note0_last", fleet_period, 32'd1612);
        idle(1);
        check_val("t1_note0_end", fleet_period, 32'd0);
        idle(20);
        pulse_step(); check_val("t1_note1", fleet_period, 32'd1818); idle(40);
        pulse_step(); check_val("t1_note2", fleet_period, 32'd2040); idle(40);
        pulse_step(); check_val("t1_note3", fleet_period, 32'd2272); idle(40);
        pulse_step(); check_val("t1_note_wrap", fleet_period, 32'd1612);

        // Mid-note restart, then no aliens.
        idle(2999);
        check_val("t2_before_restart", fleet_period, 32'd1612);
        pulse_step();
        check_val("t2_restart", fleet_period, 32'd1818);
        idle(10000);
        check_val("t2_note_done", fleet_period, 32'd0);
        alien_count = 0;
        pulse_step();
        check_val("t2_no_aliens", fleet_period, 32'd0);
        idle(5);
        alien_count = 6'd55;

        // UFO edges and UFO hit.
        ufo_active = 1;
        cycle(); check_val("t3_play_ufo", 32'(play_ufo), 32'd1);
        cycle(); check_val("t3_play_ufo_once", 32'(play_ufo), 32'd0);
        idle(5);
        ufo_active = 0;
        cycle(); check_val("t3_stop_ufo", 32'(stop_ufo), 32'd1);
        cycle(); check_val("t3_stop_ufo_once", 32'(stop_ufo), 32'd0);
        ufo_active = 1;
        idle(3);
        ev_ufo_hit = 1; cycle(); ev_ufo_hit = 0;
        check_val("t3_ufo_hit_play", 32'(play_ufo_hit), 32'd1);
        check_val("t3_ufo_hit_stop", 32'(stop_ufo), 32'd1);
        ufo_active = 0;
        idle(3);

        // Player hit priority and freeze window.
        pulse_step();
        idle(10);
        ev_player_hit = 1; ev_shoot = 1; cycle(); clear_pulses();
        check_val("t4_player_hit", 32'(play_player_hit), 32'd1);
        check_val("t4_hit_stop_ufo", 32'(stop_ufo), 32'd1);
        check_val("t4_shoot_dropped", 32'(play_shoot), 32'd0);
        check_val("t4_period_forced", fleet_period, 32'd0);
        idle(99);
        ev_player_hit = 1; fleet_step = 1; ev_alien_hit = 1; cycle(); clear_pulses();
        check_val("t4_hit_ignored", 32'(play_player_hit), 32'd0);
        check_val("t4_step_dropped", fleet_period, 32'd0);
        idle(4898);
        ev_shoot = 1; cycle(); clear_pulses();
        check_val("t4_shoot_frozen", 32'(play_shoot), 32'd0);
        idle(1);
        ev_shoot = 1; cycle(); clear_pulses();
        check_val("t4_shoot_after", 32'(play_shoot), 32'd1);

        // game_running falling/rising.
        pulse_step();
        idle(10);
        game_running = 0;
        cycle();
        check_val("t5_stop_on_gr_fall", 32'(stop_ufo), 32'd1);
        check_val("t5_period_cleared", fleet_period, 32'd0);
        ev_alien_hit = 1; fleet_step = 1; cycle(); clear_pulses();
        check_val("t5_alien_hit_suppressed", 32'(play_alien_hit), 32'd0);
        check_val("t5_step_suppressed", fleet_period, 32'd0);
        idle(3);
        game_running = 1;
        pulse_step();
        check_val("t5_idx_reset", fleet_period, 32'd1612);

`ifdef AUDIO_FLEET_SPEEDUP_EN
        // Shorter notes as the fleet thins out.
        alien_count = 6'd5;
        pulse_step(); idle(4999);
        check_val("t6_half_last", fleet_period, 32'd1818);
        idle(1); check_val("t6_half_end", fleet_period, 32'd0);
        alien_count = 6'd1;
        pulse_step(); idle(2499);
        check_val("t6_quarter_last", fleet_period, 32'd2040);
        idle(1); check_val("t6_quarter_end", fleet_period, 32'd0);
        alien_count = 6'd8;
        pulse_step(); idle(4999);
        check_val("t6_eight_last", fleet_period, 32'd2272);
        idle(1); check_val("t6_eight_end", fleet_period, 32'd0);
        alien_count = 6'd9;
        pulse_step(); idle(9999);
        check_val("t6_nine_last", fleet_period, 32'd1612);
        idle(1); check_val("t6_nine_end", fleet_period, 32'd0);
        alien_count = 6'd55;
`endif

        // Reset mid-note, then a UFO already present at reset release.
        pulse_step();
        idle(50);
        rst = 1; ufo_active = 1; cycle();
        check_val("rst_mid_note", fleet_period, 32'd0);
        game_running = 0; cycle(); rst = 0;
        idle(2);
        check_val("ufo_held_while_idle", 32'(play_ufo), 32'd0);
        game_running = 1; cycle();
        check_val("ufo_after_reset", 32'(play_ufo), 32'd1);

        // Reset mid-freeze clears the freeze.
        ev_player_hit = 1; cycle(); clear_pulses();
        idle(20);
        rst = 1; cycle(); rst = 0;
        ev_shoot = 1; cycle(); clear_pulses();
        check_val("rst_mid_freeze", 32'(play_shoot), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 399) == 0) game_running = ~game_running;
            if ($urandom_range(0, 149) == 0) ufo_active = ~ufo_active;
            if ($urandom_range(0, 299) == 0)
                alien_count = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 2))
                                                          : 6'($urandom_range(0, 55));
            fleet_step    = ($urandom_range(0, 29) == 0);
            ev_shoot      = ($urandom_range(0, 19) == 0);
            ev_alien_hit  = ($urandom_range(0, 19) == 0);
            ev_ufo_hit    = ($urandom_range(0, 59) == 0);
            ev_player_hit = ($urandom_range(0, 999) == 0);
            cycle();
        end
        rst = 0;
        clear_pulses();
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
